// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings and defaults for the memory port arbiter
package mem_arb_pkg;

  localparam logic S_CPU = 1'b0;
  localparam logic S_EXT = 1'b1;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_EXT = 1'b1;

  localparam int DEF_STARVE_LIMIT = 8;
  localparam int DEF_MAX_BURST    = 4;

  function automatic logic is_read(input logic [3:0] wea);
    return (wea == 4'b0000);
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// rtl/arb_sat_counter.sv - saturating up-counter with synchronous clear (clear wins)
module arb_sat_counter #(
  parameter int W   = 8,
  parameter int MAX = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != MAX_V)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU-priority BRAM port arbiter with starvation guard and external bursts
// Optional MEM_ARB_STATS_EN adds stall_count / ext_beats counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 14,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int MAX_BURST    = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [3:0]        cpu_wea,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_stall,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ext_req,
  input  logic              ext_lock,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [3:0]        ext_wea,
  input  logic [31:0]       ext_wdata,
  output logic              ext_gnt,
  output logic [31:0]       ext_rdata,
  output logic              ext_rvalid,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wea,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       stall_count,
  output logic [31:0]       ext_beats
`endif
);

  localparam logic [7:0] STARVE_V   = 8'(STARVE_LIMIT);
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 2);
  localparam logic       BURST_EN   = (MAX_BURST > 1);

  logic       r_state;
  logic       r_owner_q;
  logic       r_rd_q;
  logic [7:0] w_starve_cnt;
  logic [3:0] w_burst_cnt;
  logic       w_cpu_win;
  logic       w_ext_win;
  logic       w_enter_ext;
  logic       w_leave_ext;

  // In S_EXT an idle external cycle hands the port straight back to the CPU.
  always_comb begin
    w_cpu_win = 1'b0;
    w_ext_win = 1'b0;
    if (r_state == S_EXT) begin
      if (ext_req) w_ext_win = 1'b1;
      else         w_cpu_win = cpu_req;
    end else begin
      if (ext_req && (!cpu_req || (w_starve_cnt == STARVE_V))) w_ext_win = 1'b1;
      else                                                     w_cpu_win = cpu_req;
    end
  end

  assign ext_gnt   = w_ext_win;
  assign cpu_stall = cpu_req & ~w_cpu_win;

  assign mem_en    = w_cpu_win | w_ext_win;
  assign mem_addr  = w_ext_win ? ext_addr  : cpu_addr;
  assign mem_wdata = w_ext_win ? ext_wdata : cpu_wdata;
  assign mem_wea   = w_ext_win ? ext_wea : (w_cpu_win ? cpu_wea : 4'b0000);

  assign w_enter_ext = (r_state == S_CPU) & w_ext_win & ext_lock & BURST_EN;
  assign w_leave_ext = (r_state == S_EXT) &
                       (~ext_req | ~ext_lock | (w_burst_cnt == BURST_LAST));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_CPU;
      r_owner_q <= OWN_CPU;
      r_rd_q    <= 1'b0;
    end else begin
      if (w_enter_ext)      r_state <= S_EXT;
      else if (w_leave_ext) r_state <= S_CPU;
      r_owner_q <= w_ext_win ? OWN_EXT : OWN_CPU;
      r_rd_q    <= mem_en & is_read(mem_wea);
    end
  end

  arb_sat_counter #(.W(8), .MAX(STARVE_LIMIT)) u_starve_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (~ext_req | w_ext_win),
    .inc   (ext_req & ~w_ext_win),
    .cnt   (w_starve_cnt)
  );

  arb_sat_counter #(.W(4), .MAX(MAX_BURST - 1)) u_burst_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_enter_ext),
    .inc   ((r_state == S_EXT) & w_ext_win),
    .cnt   (w_burst_cnt)
  );

  assign cpu_rdata  = mem_rdata;
  assign ext_rdata  = mem_rdata;
  assign cpu_rvalid = r_rd_q & (r_owner_q == OWN_CPU);
  assign ext_rvalid = r_rd_q & (r_owner_q == OWN_EXT);

`ifdef MEM_ARB_STATS_EN
  logic [31:0] r_stall_count;
  logic [31:0] r_ext_beats;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_count <= '0;
      r_ext_beats   <= '0;
    end else begin
      if (cpu_stall) r_stall_count <= r_stall_count + 32'd1;
      if (w_ext_win) r_ext_beats   <= r_ext_beats + 32'd1;
    end
  end

  assign stall_count = r_stall_count;
  assign ext_beats   = r_ext_beats;
`endif

endmodule
